// File: rtl/axil_mem_slave_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite memory slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_DATA,
    WR_WAIT_ADDR,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_mem_slave_if.sv
// AXI4-Lite bus bundle between a master and the memory slave.
interface axil_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_mem_array.sv
// Word RAM with one byte-strobed write port and one registered read port.
// Contents clear on reset; a read that coincides with a write sees the old word.
module axil_mem_array #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 32,
  localparam int IDX_W      = $clog2(MEM_DEPTH),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  input  logic                  rzero,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data only changes on an accepted read, so it holds while R stalls.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rzero ? '0 : mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave: independent write/read FSMs in front of axil_mem_array.
// Define AXIL_MEM_SLVERR_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module axil_mem_slave
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 32
) (
  input logic              s0_axi_aclk,
  input logic              s0_axi_aresetn,
  axil_mem_slave_if.slave  s0_axi
);

  localparam int OFFS   = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFFS);
  endfunction

  wr_state_t               wr_state_q, wr_state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;

  rd_state_t               rd_state_q, rd_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    commit, commit_ok, rd_ok;
  logic [ADDR_WIDTH-1:0]   commit_addr;
  logic [DATA_WIDTH-1:0]   commit_data;
  logic [STRB_W-1:0]       commit_strb;

  assign aw_hs = s0_axi.awvalid & awready_q;
  assign w_hs  = s0_axi.wvalid  & wready_q;
  assign ar_hs = s0_axi.arvalid & arready_q;

`ifdef AXIL_MEM_SLVERR_EN
  assign commit_ok = (int'(commit_addr >> OFFS) < MEM_DEPTH);
  assign rd_ok     = (int'(s0_axi.araddr >> OFFS) < MEM_DEPTH);
`else
  assign commit_ok = 1'b1;
  assign rd_ok     = 1'b1;
`endif

  // A write commits once both halves are present, taking each half live or latched.
  always_comb begin
    commit      = 1'b0;
    commit_addr = awaddr_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_addr = s0_axi.awaddr;
          commit_data = s0_axi.wdata;
          commit_strb = s0_axi.wstrb;
        end
      end
      WR_WAIT_DATA: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = s0_axi.wdata;
          commit_strb = s0_axi.wstrb;
        end
      end
      WR_WAIT_ADDR: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_addr = s0_axi.awaddr;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    case (wr_state_q)
      WR_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs && !w_hs) begin
          awaddr_d   = s0_axi.awaddr;
          awready_d  = 1'b0;
          wr_state_d = WR_WAIT_DATA;
        end else if (w_hs && !aw_hs) begin
          wdata_d    = s0_axi.wdata;
          wstrb_d    = s0_axi.wstrb;
          wready_d   = 1'b0;
          wr_state_d = WR_WAIT_ADDR;
        end
      end
      WR_RESP: begin
        if (s0_axi.bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: ;
    endcase
    if (commit) begin
      awready_d  = 1'b0;
      wready_d   = 1'b0;
      bvalid_d   = 1'b1;
      bresp_d    = commit_ok ? RESP_OKAY : RESP_SLVERR;
      wr_state_d = WR_RESP;
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s0_axi.rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  axil_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (s0_axi_aclk),
    .rst_n (s0_axi_aresetn),
    .we    (commit & commit_ok),
    .waddr (word_idx(commit_addr)),
    .wdata (commit_data),
    .wstrb (commit_strb),
    .re    (ar_hs),
    .raddr (word_idx(s0_axi.araddr)),
    .rzero (~rd_ok),
    .rdata (s0_axi.rdata)
  );

  assign s0_axi.awready = awready_q;
  assign s0_axi.wready  = wready_q;
  assign s0_axi.bvalid  = bvalid_q;
  assign s0_axi.bresp   = bresp_q;
  assign s0_axi.arready = arready_q;
  assign s0_axi.rvalid  = rvalid_q;
  assign s0_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed plus randomized bench for axil_mem_slave against a word-array reference model.
// Build with or without AXIL_MEM_SLVERR_EN; the model follows the same macro.
module tb_axil_mem_slave;
   import axil_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   axil_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axil_mem_slave #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_DEPTH  (DEPTH)
   ) dut (
      .s0_axi_aclk    (clk),
      .s0_axi_aresetn (rst_n),
      .s0_axi         (bus)
   );

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] refMem [DEPTH];

   // Reference model: memory as a plain array of words indexed by byte address / 4.
   function automatic bit refInRange(input logic [AW-1:0] addr);
`ifdef AXIL_MEM_SLVERR_EN
      return (int'(addr) / 4) < DEPTH;
`else
      return 1'b1;
`endif
   endfunction

   function automatic int refIndex(input logic [AW-1:0] addr);
      return (int'(addr) / 4) % DEPTH;
   endfunction

   function automatic logic [1:0] refResp(input logic [AW-1:0] addr);
      return refInRange(addr) ? RESP_OKAY : RESP_SLVERR;
   endfunction

   function automatic logic [DW-1:0] refRead(input logic [AW-1:0] addr);
      return refInRange(addr) ? refMem[refIndex(addr)] : '0;
   endfunction

   task automatic refWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
      if (refInRange(addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) refMem[refIndex(addr)][8*b +: 8] = data[8*b +: 8];
         end
      end
   endtask

   task automatic refClear();
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
   endtask

   // Every comparison in the bench funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives all master outputs to their quiet values.
   task automatic applyStimulus();
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
   endtask

   // Bounded wait (at negedges) until both write readies are up.
   task automatic waitWriteReady();
      int n = 0;
      while (!(bus.awready && bus.wready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wr_ready_wait", {bus.awready, bus.wready}, 2'b11);
   endtask

   task automatic waitReadReady();
      int n = 0;
      while (!bus.arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rd_ready_wait", bus.arready, 1'b1);
   endtask

   // mode 0: AW+W together, 1: AW first then W after gap, 2: W first then AW after gap.
   task automatic writeTxn(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int mode, input int gap);
      waitWriteReady();
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      if (mode == 0) begin
         bus.awvalid = 1'b1;
         bus.wvalid  = 1'b1;
      end else if (mode == 1) begin
         bus.awvalid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.awvalid = 1'b0;
         for (int i = 0; i < gap; i++) begin
            checkOutput("aw_wait_awready", bus.awready, 1'b0);
            checkOutput("aw_wait_bvalid", bus.bvalid, 1'b0);
            @(negedge clk);
         end
         bus.wvalid = 1'b1;
      end else begin
         bus.wvalid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.wvalid = 1'b0;
         for (int i = 0; i < gap; i++) begin
            checkOutput("w_wait_wready", bus.wready, 1'b0);
            checkOutput("w_wait_awready", bus.awready, 1'b1);
            checkOutput("w_wait_bvalid", bus.bvalid, 1'b0);
            @(negedge clk);
         end
         bus.awvalid = 1'b1;
      end
      @(posedge clk);
      refWrite(addr, data, strb);
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      checkOutput("bvalid_set", bus.bvalid, 1'b1);
      checkOutput("bresp", bus.bresp, refResp(addr));
      bus.bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bready = 1'b0;
      checkOutput("bvalid_clr", bus.bvalid, 1'b0);
   endtask

   task automatic readTxn(input logic [AW-1:0] addr);
      waitReadReady();
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.arvalid = 1'b0;
      checkOutput("rvalid_set", bus.rvalid, 1'b1);
      checkOutput("rdata", bus.rdata, refRead(addr));
      checkOutput("rresp", bus.rresp, refResp(addr));
      checkOutput("arready_low", bus.arready, 1'b0);
      bus.rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rready = 1'b0;
      checkOutput("rvalid_clr", bus.rvalid, 1'b0);
   endtask

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Main directed sequence followed by a randomized phase.
   initial begin
      logic [DW-1:0] holdData;
      logic [DW-1:0] d4;
      applyStimulus();
      refClear();

      // Reset behaviour and first-edge readies.
      repeat (2) @(negedge clk);
      checkOutput("rst_awready", bus.awready, 1'b0);
      checkOutput("rst_wready", bus.wready, 1'b0);
      checkOutput("rst_arready", bus.arready, 1'b0);
      checkOutput("rst_bvalid", bus.bvalid, 1'b0);
      checkOutput("rst_bresp", bus.bresp, 2'b00);
      checkOutput("rst_rvalid", bus.rvalid, 1'b0);
      checkOutput("rst_rdata", bus.rdata, '0);
      checkOutput("rst_rresp", bus.rresp, 2'b00);
      rst_n = 1'b1;
      checkOutput("rel_awready_before_edge", bus.awready, 1'b0);
      @(negedge clk);
      checkOutput("rel_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // Simultaneous AW+W, then read back.
      writeTxn(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
      readTxn(8'h04);
      checkOutput("t2_model", refRead(8'h04), 32'hDEADBEEF);

      // W three cycles ahead of AW with a partial strobe.
      writeTxn(8'h04, 32'h12345678, 4'b0011, 2, 3);
      readTxn(8'h04);
      checkOutput("t3_model", refRead(8'h04), 32'hDEAD5678);

      // Stalled B and R: outputs hold, readies stay low, extra AW ignored.
      waitWriteReady();
      waitReadReady();
      d4 = $urandom;
      holdData = refRead(8'h04);
      bus.awaddr  = 8'h08;
      bus.wdata   = d4;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.araddr  = 8'h04;
      bus.arvalid = 1'b1;
      @(posedge clk);
      refWrite(8'h08, d4, 4'hF);
      @(negedge clk);
      bus.wvalid  = 1'b0;
      bus.arvalid = 1'b0;
      bus.awaddr  = 8'h0C;
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_bvalid", bus.bvalid, 1'b1);
         checkOutput("hold_bresp", bus.bresp, RESP_OKAY);
         checkOutput("hold_rvalid", bus.rvalid, 1'b1);
         checkOutput("hold_rdata", bus.rdata, holdData);
         checkOutput("hold_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
         @(negedge clk);
      end
      bus.awvalid = 1'b0;
      bus.bready  = 1'b1;
      bus.rready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bready = 1'b0;
      bus.rready = 1'b0;
      checkOutput("stall_end_valids", {bus.bvalid, bus.rvalid}, 2'b00);
      checkOutput("stall_end_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
      readTxn(8'h08);
      readTxn(8'h0C);

      // Out-of-range address: SLVERR or aliasing onto word 0 depending on the build.
      writeTxn(8'h80, 32'hFFFFFFFF, 4'hF, 0, 0);
      readTxn(8'h80);
      readTxn(8'h00);

      // Randomized mix of writes (all orderings) and reads over the whole address space.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            writeTxn(AW'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
         end else begin
            readTxn(AW'($urandom_range(0, 255)));
         end
      end

      // Asynchronous reset while both responses are pending.
      waitWriteReady();
      waitReadReady();
      bus.awaddr  = 8'h04;
      bus.wdata   = 32'hA5A5A5A5;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.araddr  = 8'h04;
      bus.arvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      applyStimulus();
      checkOutput("pre_rst_valids", {bus.bvalid, bus.rvalid}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_bvalid", bus.bvalid, 1'b0);
      checkOutput("async_rst_rvalid", bus.rvalid, 1'b0);
      checkOutput("async_rst_rdata", bus.rdata, '0);
      refClear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      readTxn(8'h04);
      readTxn(8'h08);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
